rom_read_arbiter: RTL and testbench

- Shares the single-read-port image ROM (12-bit RGB444 words, 19-bit address) between two requesters.
- Port 0 is the VGA pixel fetch and has priority. Port 1 is the sprite/background loader.
- Issues at most one ROM read per clock and tracks the in-flight reads through the ROM's fixed read latency.
- Returns each word to the port that issued it, with a valid strobe; a starvation guard caps how long port 1 can wait.

---
 rtl/rom_read_arbiter.sv | 121 ++++++++++++
 tb/tb_rom_read_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter in front of a single-port image ROM. Port 0 (pixel fetch)
// has priority, and a starvation guard bounds how long port 1 can wait.
module rom_read_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12,
  parameter int LAT      = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              vld0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              vld1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [LAT-1:0]    tag_vld_q, tag_vld_d;
  logic [LAT-1:0]    tag_port_q, tag_port_d;
  logic              vld0_q, vld0_d;
  logic              vld1_q, vld1_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              force_s;

  // Arbitration: a starved port 1 beats port 0; otherwise port 0 has priority.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rom_addr = '0;
    force_s  = req1 && (wait_cnt_q >= MAX_WAIT_C);
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (force_s) begin
      gnt1 = 1'b1;
    end else if (req0) begin
      gnt0 = 1'b1;
    end else if (req1) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) begin
      rom_addr = addr0;
    end else if (gnt1) begin
      rom_addr = addr1;
    end else begin
      rom_addr = '0;
    end
  end

  // Next state: starvation counter, tag shift register and return register.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    tag_vld_d  = tag_vld_q;
    tag_port_d = tag_port_q;
    vld0_d     = 1'b0;
    vld1_d     = 1'b0;
    rd_data_d  = rd_data_q;

    if (!req1 || gnt1) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    for (int i = LAT - 1; i > 0; i--) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_port_d[i] = tag_port_q[i-1];
    end
    tag_vld_d[0]  = gnt0 | gnt1;
    tag_port_d[0] = gnt1;

    // The last tag stage lines up with the cycle douta is valid.
    if (tag_vld_q[LAT-1]) begin
      rd_data_d = rom_data;
      vld0_d    = !tag_port_q[LAT-1];
      vld1_d    = tag_port_q[LAT-1];
    end else begin
      rd_data_d = rd_data_q;
      vld0_d    = 1'b0;
      vld1_d    = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
      tag_vld_q  <= '0;
      tag_port_q <= '0;
      vld0_q     <= 1'b0;
      vld1_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
      vld0_q     <= vld0_d;
      vld1_q     <= vld1_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign vld0    = vld0_q;
  assign vld1    = vld1_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: one instance at LAT=1/MAX_WAIT=4 and one
// at LAT=2/MAX_WAIT=8, each fed by a behavioural ROM of matching latency.
module tb_rom_read_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req0_a, req1_a, gnt0_a, gnt1_a, vld0_a, vld1_a;
  logic [18:0] addr0_a, addr1_a, rom_addr_a;
  logic [11:0] rom_data_a, rd_data_a;

  logic        req0_b, req1_b, gnt0_b, gnt1_b, vld0_b, vld1_b;
  logic [18:0] addr0_b, addr1_b, rom_addr_b;
  logic [11:0] rom_data_b, rom_stage_b, rd_data_b;

  int total = 0;
  int passed = 0;
  int failed = 0;

  rom_read_arbiter #(.ADDR_W(19), .DATA_W(12), .LAT(1), .MAX_WAIT(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_a), .addr0(addr0_a), .gnt0(gnt0_a), .vld0(vld0_a),
    .req1(req1_a), .addr1(addr1_a), .gnt1(gnt1_a), .vld1(vld1_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .rd_data(rd_data_a)
  );

  rom_read_arbiter #(.ADDR_W(19), .DATA_W(12), .LAT(2), .MAX_WAIT(8)) u2 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_b), .addr0(addr0_b), .gnt0(gnt0_b), .vld0(vld0_b),
    .req1(req1_b), .addr1(addr1_b), .gnt1(gnt1_b), .vld1(vld1_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .rd_data(rd_data_b)
  );

  function automatic logic [11:0] rom_word(input logic [18:0] a);
    return a[11:0] ^ {5'd0, a[18:12]} ^ 12'h5A3;
  endfunction

  // Behavioural ROMs: latency 1 and latency 2, independent of reset.
  always @(posedge clk) begin
    rom_data_a  <= rom_word(rom_addr_a);
    rom_stage_b <= rom_word(rom_addr_b);
    rom_data_b  <= rom_stage_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [18:0] tab_a0 [4];
  logic [18:0] tab_a1 [4];
  logic [18:0] seq_addr [4];
  logic        e_g0, e_g1, e_v0, e_v1;
  logic [31:0] e_wait;

  initial begin
    rst_n = 1'b0;
    req0_a = 1'b1; addr0_a = 19'h00055; req1_a = 1'b1; addr1_a = 19'h00066;
    req0_b = 1'b0; addr0_b = 19'h0;     req1_b = 1'b0; addr1_b = 19'h0;

    // Reset: grants suppressed even with both requests up.
    tick;
    chk("rst_gnt0", 32'(gnt0_a), 32'd0);
    chk("rst_gnt1", 32'(gnt1_a), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr_a), 32'd0);
    chk("rst_vld0", 32'(vld0_a), 32'd0);
    chk("rst_vld1", 32'(vld1_a), 32'd0);
    chk("rst_rd_data", 32'(rd_data_a), 32'd0);
    chk("rst_wait_cnt", 32'(u1.wait_cnt_q), 32'd0);
    tick;
    rst_n = 1'b1; req0_a = 1'b0; req1_a = 1'b0; addr0_a = 19'h0; addr1_a = 19'h0;

    // Idle: no grants, no address, no returns.
    for (int k = 0; k < 20; k++) begin
      tick;
      chk("idle_gnt_a", 32'({gnt0_a, gnt1_a}), 32'd0);
      chk("idle_addr_a", 32'(rom_addr_a), 32'd0);
      chk("idle_vld_a", 32'({vld0_a, vld1_a}), 32'd0);
      chk("idle_gnt_b", 32'({gnt0_b, gnt1_b}), 32'd0);
      chk("idle_vld_b", 32'({vld0_b, vld1_b}), 32'd0);
    end

    // Single port-0 read, LAT=1: return two cycles after the grant.
    tick;
    req0_a = 1'b1; addr0_a = 19'h00010;
    #1;
    chk("p0_gnt0", 32'(gnt0_a), 32'd1);
    chk("p0_gnt1", 32'(gnt1_a), 32'd0);
    chk("p0_rom_addr", 32'(rom_addr_a), 32'h00010);
    tick;
    req0_a = 1'b0;
    chk("p0_vld0_t1", 32'(vld0_a), 32'd0);
    chk("p0_vld1_t1", 32'(vld1_a), 32'd0);
    tick;
    chk("p0_vld0_t2", 32'(vld0_a), 32'd1);
    chk("p0_vld1_t2", 32'(vld1_a), 32'd0);
    chk("p0_rd_data", 32'(rd_data_a), 32'(rom_word(19'h00010)));
    tick;
    chk("p0_vld0_t3", 32'(vld0_a), 32'd0);
    chk("p0_hold_data", 32'(rd_data_a), 32'(rom_word(19'h00010)));

    // Single port-1 read.
    tick;
    req1_a = 1'b1; addr1_a = 19'h4B000;
    #1;
    chk("p1_gnt1", 32'(gnt1_a), 32'd1);
    chk("p1_gnt0", 32'(gnt0_a), 32'd0);
    chk("p1_rom_addr", 32'(rom_addr_a), 32'h4B000);
    chk("p1_wait0", 32'(u1.wait_cnt_q), 32'd0);
    tick;
    req1_a = 1'b0;
    chk("p1_wait1", 32'(u1.wait_cnt_q), 32'd0);
    tick;
    chk("p1_vld1", 32'(vld1_a), 32'd1);
    chk("p1_vld0", 32'(vld0_a), 32'd0);
    chk("p1_rd_data", 32'(rd_data_a), 32'(rom_word(19'h4B000)));
    tick;
    chk("p1_vld1_off", 32'(vld1_a), 32'd0);
    tick;

    // Contention with MAX_WAIT=4: port 1 forced through at k=4 and k=9.
    tick;
    req0_a = 1'b1; addr0_a = 19'h01234;
    req1_a = 1'b1; addr1_a = 19'h4B000;
    for (int k = 0; k < 12; k++) begin
      #1;
      e_g1 = (k == 4) || (k == 9);
      e_g0 = !e_g1;
      e_v1 = (k == 6) || (k == 11);
      e_v0 = (k >= 2) && !e_v1;
      e_wait = (k < 5) ? 32'(k) : ((k < 10) ? 32'(k - 5) : 32'(k - 10));
      chk("st_gnt0", 32'(gnt0_a), 32'(e_g0));
      chk("st_gnt1", 32'(gnt1_a), 32'(e_g1));
      chk("st_rom_addr", 32'(rom_addr_a), e_g1 ? 32'h4B000 : 32'h01234);
      chk("st_wait_cnt", 32'(u1.wait_cnt_q), e_wait);
      chk("st_vld0", 32'(vld0_a), 32'(e_v0));
      chk("st_vld1", 32'(vld1_a), 32'(e_v1));
      if (e_v0 || e_v1) begin
        chk("st_rd_data", 32'(rd_data_a),
            e_v1 ? 32'(rom_word(19'h4B000)) : 32'(rom_word(19'h01234)));
      end
      tick;
    end
    req0_a = 1'b0; req1_a = 1'b0;
    tick;
    tick;

    // LAT=2 alternating 0,1,0,1: returns in issue order starting three cycles later.
    tab_a0[0] = 19'h00100; tab_a0[1] = 19'h0;     tab_a0[2] = 19'h7FFFF; tab_a0[3] = 19'h0;
    tab_a1[0] = 19'h0;     tab_a1[1] = 19'h12345; tab_a1[2] = 19'h0;     tab_a1[3] = 19'h00ABC;
    seq_addr[0] = 19'h00100; seq_addr[1] = 19'h12345;
    seq_addr[2] = 19'h7FFFF; seq_addr[3] = 19'h00ABC;
    tick;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        req0_b = (k % 2 == 0); addr0_b = tab_a0[k];
        req1_b = (k % 2 == 1); addr1_b = tab_a1[k];
      end else begin
        req0_b = 1'b0; addr0_b = 19'h0;
        req1_b = 1'b0; addr1_b = 19'h0;
      end
      #1;
      e_g0 = (k == 0) || (k == 2);
      e_g1 = (k == 1) || (k == 3);
      e_v0 = (k == 3) || (k == 5);
      e_v1 = (k == 4) || (k == 6);
      chk("alt_gnt0", 32'(gnt0_b), 32'(e_g0));
      chk("alt_gnt1", 32'(gnt1_b), 32'(e_g1));
      chk("alt_rom_addr", 32'(rom_addr_b), (k < 4) ? 32'(seq_addr[k]) : 32'd0);
      chk("alt_vld0", 32'(vld0_b), 32'(e_v0));
      chk("alt_vld1", 32'(vld1_b), 32'(e_v1));
      if (e_v0 || e_v1) begin
        chk("alt_rd_data", 32'(rd_data_b), 32'(rom_word(seq_addr[k-3])));
      end
      tick;
    end

    // Reset one cycle after a grant: the in-flight read must not return.
    req0_a = 1'b1; addr0_a = 19'h22222;
    req1_a = 1'b1; addr1_a = 19'h33333;
    #1;
    chk("mr_gnt0", 32'(gnt0_a), 32'd1);
    tick;
    rst_n = 1'b0;
    #1;
    chk("mr_gnt0_rst", 32'(gnt0_a), 32'd0);
    chk("mr_gnt1_rst", 32'(gnt1_a), 32'd0);
    chk("mr_addr_rst", 32'(rom_addr_a), 32'd0);
    chk("mr_wait_pre", 32'(u1.wait_cnt_q), 32'd1);
    tick;
    chk("mr_gnt_rst2", 32'({gnt0_a, gnt1_a}), 32'd0);
    chk("mr_vld0", 32'(vld0_a), 32'd0);
    chk("mr_vld1", 32'(vld1_a), 32'd0);
    chk("mr_rd_data", 32'(rd_data_a), 32'd0);
    chk("mr_wait_cnt", 32'(u1.wait_cnt_q), 32'd0);
    tick;
    rst_n = 1'b1; req0_a = 1'b0; req1_a = 1'b0;
    chk("mr_vld_after1", 32'({vld0_a, vld1_a}), 32'd0);
    tick;
    chk("mr_vld_after2", 32'({vld0_a, vld1_a}), 32'd0);
    chk("mr_rd_data_after", 32'(rd_data_a), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
